// File: rtl/m_mem_ctrl_if.sv
// Data-memory bus between the M-stage controller and the memory.
//   mem_req   : bus request, held high for the whole access
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables
//   mem_wdata : lane-replicated store data
//   mem_ack   : completion; mem_rdata is valid in the same cycle
//   mem_rdata : read word
interface m_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller.
// Runs one word-aligned req/ack bus transaction per load/store taken from the
// E/M register, stalls the pipeline until it completes, and returns extended
// load data plus alignment / bus-error flags with a one-cycle rdata_valid.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_we/req_type/req_addr/req_wdata : M-stage memory instruction
//   stall       : hold PC/F/D/E/M registers this cycle
//   rdata_out   : extended load data (valid with rdata_valid)
//   rdata_valid : one-cycle completion pulse
//   exc_adel/exc_ades/bus_err : misaligned load/store, timeout
//   bus         : data-memory bus (master side)
module m_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              bus_err,
  m_mem_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        lat_type;
  logic [1:0]        lat_lane;
  logic              lat_we;

  logic              is_byte;
  logic              is_half;
  logic              misaligned;
  logic [3:0]        be_next;
  logic [31:0]       wdata_next;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // Request decode: size, alignment, byte enables and lane-replicated data.
  always_comb begin
    is_byte    = (req_type == 3'b011) || (req_type == 3'b100);
    is_half    = (req_type == 3'b001) || (req_type == 3'b010);
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << req_addr[1:0];
      wdata_next = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      misaligned = req_addr[0];
      be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{req_wdata[15:0]}};
    end else begin
      misaligned = |req_addr[1:0];
    end
  end

  // Load lane extraction uses the latched type/lane, not the live request.
  always_comb begin
    case (lat_lane)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lat_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (lat_type)
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = {16'h0000, ld_half};
      3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  assign stall = reset & req_valid & (state != S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_type      <= '0;
      lat_lane      <= '0;
      lat_we        <= 1'b0;
      rdata_out     <= '0;
      rdata_valid   <= 1'b0;
      exc_adel      <= 1'b0;
      exc_ades      <= 1'b0;
      bus_err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rdata_out <= '0;
            cnt       <= '0;
            if (misaligned) begin
              exc_adel    <= ~req_we;
              exc_ades    <= req_we;
              rdata_valid <= 1'b1;
              state       <= S_DONE;
            end else begin
              lat_type      <= req_type;
              lat_lane      <= req_addr[1:0];
              lat_we        <= req_we;
              bus.mem_we    <= req_we;
              bus.mem_addr  <= {req_addr[31:2], 2'b00};
              bus.mem_be    <= be_next;
              bus.mem_wdata <= wdata_next;
              bus.mem_req   <= 1'b1;
              state         <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // Ack is tested first so an ack on the last allowed cycle wins.
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            rdata_out   <= lat_we ? '0 : ld_data;
            rdata_valid <= 1'b1;
            state       <= S_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.mem_req <= 1'b0;
            bus_err     <= 1'b1;
            rdata_out   <= '0;
            rdata_valid <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          rdata_valid <= 1'b0;
          exc_adel    <= 1'b0;
          exc_ades    <= 1'b0;
          bus_err     <= 1'b0;
          rdata_out   <= '0;
          cnt         <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
module tb_m_mem_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid, exc_adel, exc_ades, bus_err;

  m_mem_ctrl_if bus ();

  m_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_type    (req_type),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .bus_err     (bus_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sz(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
    return (a % sz(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    int n = sz(t);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
    case (sz(t))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] r);
    int n = sz(t);
    longint v;
    longint span;
    if (n == 4) return r;
    span = longint'(1) << (8 * n);
    v = (longint'(r) >> (8 * (a % 4))) % span;
    if ((t == 3'd1 || t == 3'd3) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // ---------------- current transaction ----------------
  bit          active;
  int          k, total, t_waits;
  bit          t_mis, t_we, t_tmo;
  logic [2:0]  t_type;
  logic [31:0] t_addr, t_wdata, t_rdata;
  int          obs_stall, obs_req;
  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we, last_adel, last_ades, last_berr;

  // One compare process, every cycle, at the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_stall", stall, 0);
      chk("rst_req", bus.mem_req, 0);
      chk("rst_valid", rdata_valid, 0);
      chk("rst_flags", {exc_adel, exc_ades, bus_err}, 0);
      chk("rst_rdata", rdata_out, 0);
      chk("rst_addr", bus.mem_addr, 0);
    end else if (active) begin
      bit exp_req;
      chk("stall", stall, (k < total));
      exp_req = !t_mis && k >= 1 && k < total;
      chk("mem_req", bus.mem_req, exp_req);
      if (exp_req) begin
        chk("mem_addr", bus.mem_addr, t_addr & ~32'd3);
        chk("mem_be", bus.mem_be, m_be(t_type, t_addr));
        chk("mem_we", bus.mem_we, t_we);
        chk("mem_wdata", bus.mem_wdata, m_wdata(t_type, t_wdata));
      end
      chk("rdata_valid", rdata_valid, (k == total));
      if (k == total) begin
        chk("rdata_out", rdata_out,
            (t_mis || t_we || t_tmo) ? 32'd0 : m_load(t_type, t_addr, t_rdata));
        chk("exc_adel", exc_adel, t_mis && !t_we);
        chk("exc_ades", exc_ades, t_mis && t_we);
        chk("bus_err", bus_err, t_tmo);
        last_rdata = rdata_out;
        last_adel  = exc_adel;
        last_ades  = exc_ades;
        last_berr  = bus_err;
      end else begin
        chk("flags_idle", {exc_adel, exc_ades, bus_err}, 0);
      end
      if (stall) obs_stall++;
      if (bus.mem_req) begin
        obs_req++;
        last_addr  = bus.mem_addr;
        last_be    = bus.mem_be;
        last_wdata = bus.mem_wdata;
        last_we    = bus.mem_we;
      end
    end else begin
      chk("idle_stall", stall, 0);
      chk("idle_req", bus.mem_req, 0);
      chk("idle_valid", rdata_valid, 0);
      chk("idle_flags", {exc_adel, exc_ades, bus_err}, 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  // waits < 0 means the memory never acknowledges.
  task automatic run_txn(input bit we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int bcnt = 0;
    t_we = we; t_type = t; t_addr = a; t_wdata = wd; t_rdata = rd; t_waits = waits;
    t_mis = m_mis(t, a);
    t_tmo = !t_mis && (waits < 0 || waits >= TO);
    total = t_mis ? 1 : (t_tmo ? TO + 1 : waits + 2);
    obs_stall = 0; obs_req = 0;
    last_rdata = 'x; last_addr = 'x; last_wdata = 'x; last_be = 'x; last_we = 'x;
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    k = 0; active = 1'b1;
    while (k < total) begin
      @(posedge clk); #1;
      k++;
      if (bus.mem_req && bcnt == waits) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      end else begin
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      end
      if (bus.mem_req) bcnt++;
    end
    @(posedge clk); #1;
    active = 1'b0;
    bus.mem_ack = 1'b0;
    req_valid = 1'b0; req_we = $urandom; req_type = $urandom; req_addr = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; active = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0;
    req_addr = 32'h1004; req_wdata = '0;
    bus.mem_ack = 1'b1; bus.mem_rdata = '0;
    #23;
    req_valid = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Directed cases with literal expectations.
    run_txn(0, 3'd0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_data", last_rdata, 32'hDEAD_BEEF);
    chk("lw_stall", obs_stall, 2);
    chk("lw_addr", last_addr, 32'h0000_1004);
    chk("lw_be", last_be, 4'b1111);
    run_txn(0, 3'd3, 32'h1003, 32'h0, 32'h80FF_0000, 1);
    chk("lb_data", last_rdata, 32'hFFFF_FF80);
    run_txn(0, 3'd4, 32'h1003, 32'h0, 32'h80FF_0000, 0);
    chk("lbu_data", last_rdata, 32'h0000_0080);
    run_txn(0, 3'd2, 32'h1002, 32'h0, 32'h80FF_0000, 2);
    chk("lhu_data", last_rdata, 32'h0000_80FF);
    idle(1);
    run_txn(1, 3'd3, 32'h2001, 32'h1234_56AB, 32'h0, 3);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("sb_we", last_we, 1);
    chk("sb_stall", obs_stall, 5);
    chk("sb_flags", {last_adel, last_ades, last_berr}, 0);
    run_txn(0, 3'd0, 32'h1002, 32'h0, 32'h0, 0);
    chk("lw_mis_req", obs_req, 0);
    chk("lw_mis_stall", obs_stall, 1);
    chk("lw_mis_adel", last_adel, 1);
    chk("lw_mis_data", last_rdata, 0);
    run_txn(1, 3'd1, 32'h1001, 32'h5555, 32'h0, 0);
    chk("sh_mis_ades", last_ades, 1);
    run_txn(0, 3'd0, 32'h3000, 32'h0, 32'h0, -1);
    chk("tmo_req_cycles", obs_req, 16);
    chk("tmo_berr", last_berr, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    idle(1);
    bus.mem_ack = 1'b0;
    idle(1);
    run_txn(0, 3'd0, 32'h3004, 32'h0, 32'h0BAD_F00D, TO - 1);
    chk("ack_wins_berr", last_berr, 0);
    chk("ack_wins_data", last_rdata, 32'h0BAD_F00D);
    run_txn(1, 3'd0, 32'h4000, 32'hCAFE_0001, 32'h0, 0);
    run_txn(0, 3'd0, 32'h4000, 32'h0, 32'h1357_9BDF, 0);
    chk("b2b_stall", obs_stall, 2);
    chk("b2b_data", last_rdata, 32'h1357_9BDF);

    // Reset pulled low mid-BUSY.
    t_we = 0; t_type = 3'd0; t_addr = 32'h5000; t_wdata = 0; t_rdata = 0;
    t_mis = 0; t_tmo = 1; total = TO + 1;
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h5000;
    k = 0; active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; k++;
    end
    #2;
    reset = 1'b0; active = 1'b0;
    #1;
    chk("arst_req", bus.mem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_valid", rdata_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    idle(3);
    run_txn(0, 3'd4, 32'h5002, 32'h0, 32'h00AB_0000, 1);
    chk("post_rst_data", last_rdata, 32'h0000_00AB);

    // Randomized traffic against the model.
    for (int i = 0; i < 120; i++) begin
      int w;
      int r = $urandom_range(0, 19);
      w = (r == 0) ? -1 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(0, 5);
      run_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
